// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron sequencer: FSM states and datapath widths.
// Latency: n/a (package).
// Backpressure: n/a (package).
package neuron_pkg;

  localparam int DATA_W   = 18;  // signed fixed-point operand/result width
  localparam int ACC_W    = 40;  // signed accumulator width
  localparam int FRAC_DEF = 14;  // default fractional bits

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    ACT   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/neuron_mac.sv
// Multiply-accumulate: acc += x*w (full 36-bit product) when en, cleared by clr.
// Latency: 1 cycle from en to updated acc; clr has priority over en.
// Backpressure: none, accumulates whenever en is high.
// Ports: clk/rst (sync, active-high), clr, en, x_data/w_data operands, acc result.
module neuron_mac
  import neuron_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = x_data * w_data;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_seq.sv
// Neuron evaluation sequencer: streams len operand pairs, MACs them, adds bias,
//   applies ReLU. Optional saturation with NEURON_SEQ_SAT_EN (default: wrap).
// Latency: result valid after edge len+3 (len>0) or edge 2 (len==0) from start.
// Backpressure: result held in DONE until out_valid&&out_ready; start ignored
//   while busy.
// Ports: clk/rst (sync, active-high); start/len/bias request; rd_en/rd_addr
//   operand reads with x_data/w_data returning one cycle later; busy;
//   out_valid/out_ready/out_data/sat_flag result handshake.
module neuron_seq
  import neuron_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat_flag
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

  state_t                   state_d, state_q;
  logic [ADDR_W:0]          len_d, len_q, len_clip;
  logic signed [DATA_W-1:0] bias_d, bias_q;
  logic                     rd_en_d, rd_en_q;
  logic [ADDR_W-1:0]        rd_addr_d, rd_addr_q;
  logic                     dvld_q;  // operand data on x_data/w_data is live
  logic signed [DATA_W-1:0] pre_d, pre_q;
  logic                     pre_sat_d, pre_sat_q;
  logic                     out_valid_d, out_valid_q;
  logic signed [DATA_W-1:0] out_data_d, out_data_q;
  logic                     sat_d, sat_q;
  logic                     mac_clr;
  logic signed [ACC_W-1:0]  acc;

  logic signed [ACC_W:0]    bias_ext, sum, pre_full;
  logic signed [DATA_W-1:0] pre_red;
  logic                     pre_sat;

  neuron_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (dvld_q),
    .x_data (x_data),
    .w_data (w_data),
    .acc    (acc)
  );

  // Bias aligned to the product's binary point; one extra bit so the
  // bias addition itself cannot wrap before the shift back down.
  always_comb begin
    bias_ext = {{(ACC_W+1-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    sum      = {acc[ACC_W-1], acc} + (bias_ext <<< FRAC);
    pre_full = sum >>> FRAC;
  end

`ifdef NEURON_SEQ_SAT_EN
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2**(DATA_W-1)));

  always_comb begin
    pre_red = pre_full[DATA_W-1:0];
    pre_sat = 1'b0;
    if (pre_full > SAT_HI) begin
      pre_red = SAT_HI[DATA_W-1:0];
      pre_sat = 1'b1;
    end else if (pre_full < SAT_LO) begin
      pre_red = SAT_LO[DATA_W-1:0];
      pre_sat = 1'b1;
    end
  end
`else
  logic unused_pre_hi;

  // Two's-complement wrap: keep the low result bits only.
  assign pre_red       = pre_full[DATA_W-1:0];
  assign pre_sat       = 1'b0;
  assign unused_pre_hi = ^pre_full[ACC_W:DATA_W];
`endif

  assign len_clip = (len > LEN_MAX) ? LEN_MAX : len;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bias_d      = bias_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    pre_d       = pre_q;
    pre_sat_d   = pre_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    mac_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len_clip;
          bias_d    = bias;
          mac_clr   = 1'b1;
          rd_addr_d = '0;
          if (len_clip != '0) begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end else begin
            state_d = BIAS;
          end
        end
      end
      FETCH: begin
        if ({1'b0, rd_addr_q} == len_q - (ADDR_W+1)'(1)) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      // Last operand pair lands on x_data/w_data during this cycle.
      DRAIN: state_d = BIAS;
      BIAS: begin
        pre_d     = pre_red;
        pre_sat_d = pre_sat;
        state_d   = ACT;
      end
      ACT: begin
        out_data_d  = pre_q[DATA_W-1] ? '0 : pre_q;
        sat_d       = pre_sat_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          sat_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      bias_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      dvld_q      <= 1'b0;
      pre_q       <= '0;
      pre_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      dvld_q      <= rd_en_q;
      pre_q       <= pre_d;
      pre_sat_q   <= pre_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Self-checking bench for neuron_seq: directed vector table, held-output and
// mid-fetch reset sequences, and random evaluations against an arithmetic model.
module tb_neuron_seq;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [6:0]         len;
  logic signed [17:0] bias, x_data, w_data, out_data;
  logic               rd_en, busy, out_valid, sat_flag;
  logic [5:0]         rd_addr;

  logic signed [17:0] x_mem [64];
  logic signed [17:0] w_mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .x_data    (x_data),
    .w_data    (w_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  // Operand memory: one-cycle read latency; data holds when not read.
  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= x_mem[rd_addr];
      w_data <= w_mem[rd_addr];
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int n, input int xa, input int xb, input int wv);
    for (int i = 0; i < 64; i++) begin
      x_mem[i] = 18'((i == 0) ? xa : xb);
      w_mem[i] = 18'(wv);
    end
    if (n < 0) $display("note: negative fill length");
  endtask

  // Reference: exact dot product, floor-divided bias-aligned sum, then
  // clamp or wrap to 18 bits, then ReLU on the sign.
  task automatic model(input int n, input int b, output int eo, output int es);
    longint s, pre, r;
    s = longint'(b) * 16384;
    for (int i = 0; i < n; i++) s += longint'(x_mem[i]) * longint'(w_mem[i]);
    if (s >= 0) pre = s / 16384;
    else        pre = -((-s + 16383) / 16384);
    es = 0;
`ifdef NEURON_SEQ_SAT_EN
    r = pre;
    if (pre > 131071)  begin r = 131071;  es = 1; end
    if (pre < -131072) begin r = -131072; es = 1; end
`else
    r = pre % 262144;
    if (r < 0) r += 262144;
    if (r >= 131072) r -= 262144;
`endif
    eo = (r < 0) ? 0 : int'(r);
  endtask

  task automatic run_eval(input string nm, input int n, input int b,
                          input int exp_out, input int exp_sat,
                          input int exp_lat, input int hold);
    int lat, reads;
    bit seq_ok, held_ok;
    lat = -1; reads = 0; seq_ok = 1; held_ok = 1;
    @(negedge clk);
    start = 1'b1; len = 7'(n); bias = 18'(b);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (rd_en !== (k < n)) seq_ok = 0;
      if (rd_en && rd_addr != 6'(k)) seq_ok = 0;
      if (busy !== 1'b1) seq_ok = 0;
      if (rd_en) reads++;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " out_data"}, longint'(out_data), exp_out);
    chk({nm, " sat_flag"}, sat_flag, exp_sat);
    chk({nm, " reads"}, reads, n);
    chk({nm, " read_seq"}, seq_ok, 1);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        start = (h == 3);
        @(negedge clk);
        if (!out_valid || !busy || longint'(out_data) != exp_out ||
            sat_flag != exp_sat[0]) held_ok = 0;
      end
      start = 1'b0;
      chk({nm, " held"}, held_ok, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " idle_after_accept"}, {busy, out_valid}, 0);
  endtask

  typedef struct {
    int n; int xa; int xb; int wv; int b;
    int exp_out; int exp_sat; int exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int eo, es, n, b, found;

    tbl[0] = '{2, 16384, 8192, 16384, 0, 24576, 0, 5};
    tbl[1] = '{1, 16384, 16384, -16384, 0, 0, 0, 4};
    tbl[2] = '{0, 0, 0, 0, 500, 500, 0, 2};
    tbl[3] = '{0, 0, 0, 0, -100, 0, 0, 2};
`ifdef NEURON_SEQ_SAT_EN
    tbl[4] = '{4, 131071, 131071, 131071, 0, 131071, 1, 7};
`else
    tbl[4] = '{4, 131071, 131071, 131071, 0, 0, 0, 7};
`endif
    tbl[5] = '{64, 16384, 16384, 256, 0, 16384, 0, 67};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; len = '0; bias = '0;
    x_data = 18'sd777; w_data = 18'sd777;
    fill(64, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rd_en", rd_en, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", longint'(out_data), 0);
    chk("reset sat_flag", sat_flag, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].n, tbl[i].xa, tbl[i].xb, tbl[i].wv);
      run_eval($sformatf("vec%0d", i), tbl[i].n, tbl[i].b,
               tbl[i].exp_out, tbl[i].exp_sat, tbl[i].exp_lat, 0);
    end

    // Consumer stalls for 10 cycles while a stray start is pulsed.
    fill(2, 16384, 8192, 16384);
    run_eval("hold", 2, 0, 24576, 0, 5, 10);

    // Reset in the middle of a long fetch; stale return data must be dropped.
    fill(8, 30000, 30000, 30000);
    @(negedge clk);
    start = 1'b1; len = 7'd8; bias = 18'sd0;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 6'd3) begin
        found = 1;
        break;
      end
    end
    chk("midfetch reached addr3", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midfetch reset outputs", {rd_en, busy, out_valid}, 0);
    fill(2, 16384, 8192, 16384);
    run_eval("after_reset", 2, 0, 24576, 0, 5, 0);

    // Random evaluations against the model.
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(0, 64));
      b = int'($urandom_range(0, 262143)) - 131072;
      for (int i = 0; i < 64; i++) begin
        x_mem[i] = 18'(int'($urandom_range(0, 131070)) - 65535);
        w_mem[i] = 18'(int'($urandom_range(0, 131070)) - 65535);
      end
      model(n, b, eo, es);
      run_eval($sformatf("rand%0d", t), n, b, eo, es, (n == 0) ? 2 : n + 3,
               (t % 3 == 0) ? 4 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
